// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the stream demultiplexer.
package stream_demux_pkg;

    // Packet-tracking state: no packet open, or a packet open on a held channel.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int N_OUT_DEF  = 4;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready register slice holding a single beat for one channel.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int W = DATA_W_DEF + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         push;

    // The slot can take a beat when empty or when its current beat leaves this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign push      = in_valid && in_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Refill wins over drain so a simultaneous drain and refill keeps the slot full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (push) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers; contents only change on a push, so they hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Packet-aware 1-to-N stream demultiplexer: the first beat of a packet picks the
// channel, the remaining beats follow it until in_last.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int N_OUT  = N_OUT_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_last,
    output logic                    err_sel
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0] tgt;
    logic             tgt_ok;
    logic             tgt_rdy;
    logic             accept;
    logic [N_OUT-1:0] slot_rdy;
    logic [N_OUT-1:0] slot_in_vld;
    logic [DATA_W:0]  slot_dout [N_OUT];

    // In IDLE the incoming select decides; inside a packet the held channel does.
    assign tgt    = (state_q == IDLE) ? in_sel : ch_q;
    assign tgt_ok = ({1'b0, tgt} < (SEL_W + 1)'(N_OUT));
    assign accept = in_valid && in_ready;
    assign in_ready = !rst && tgt_rdy;
    assign err_sel  = err_q;

    // Pick the target slot's readiness and steer the accepted beat to it; an
    // out-of-range target matches no slot, so its beats are accepted and dropped.
    always_comb begin
        tgt_rdy     = 1'b1;
        slot_in_vld = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (tgt == SEL_W'(k)) begin
                tgt_rdy        = slot_rdy[k];
                slot_in_vld[k] = accept;
            end
        end
    end

    // Packet tracking: open on a non-last first beat, close on any accepted last beat.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        err_d   = err_q;
        if (accept) begin
            if (state_q == IDLE) begin
                ch_d = in_sel;
                if (!tgt_ok) begin
                    err_d = 1'b1;
                end
                if (!in_last) begin
                    state_d = LOCKED;
                end
            end else if (in_last) begin
                state_d = IDLE;
            end
        end
    end

    // Control registers; reset abandons any open packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            err_q   <= err_d;
        end
    end

    for (genvar gk = 0; gk < N_OUT; gk++) begin : g_slot
        demux_slot #(
            .W(DATA_W + 1)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .in_valid (slot_in_vld[gk]),
            .in_ready (slot_rdy[gk]),
            .in_data  ({in_last, in_data}),
            .out_valid(out_valid[gk]),
            .out_ready(out_ready[gk]),
            .out_data (slot_dout[gk])
        );

        assign out_data[gk*DATA_W +: DATA_W] = slot_dout[gk][DATA_W-1:0];
        assign out_last[gk]                  = slot_dout[gk][DATA_W];
    end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: per-channel expected-beat queues fed by a packet-level
// routing model, plus a 3-channel instance for out-of-range selects.
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 4-channel instance
    logic        v4 = 1'b0, l4 = 1'b0;
    logic [7:0]  d4 = '0;
    logic [1:0]  s4 = '0;
    logic [3:0]  or4 = '0;
    logic        rdy4, err4;
    logic [3:0]  ov4, ol4;
    logic [31:0] od4;

    // 3-channel instance
    logic        v3 = 1'b0, l3 = 1'b0;
    logic [7:0]  d3 = '0;
    logic [1:0]  s3 = '0;
    logic [2:0]  or3 = '0;
    logic        rdy3, err3;
    logic [2:0]  ov3, ol3;
    logic [23:0] od3;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: beats accepted but not yet taken, per channel.
    logic [8:0] exp_q [4][$];
    bit         pkt_open = 0;
    int         pkt_dest = 0;

    always #5 clk = ~clk;

    stream_demux #(.N_OUT(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
        .in_last(l4), .in_sel(s4), .out_valid(ov4), .out_ready(or4),
        .out_data(od4), .out_last(ol4), .err_sel(err4)
    );

    stream_demux #(.N_OUT(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
        .in_last(l3), .in_sel(s3), .out_valid(ov3), .out_ready(or3),
        .out_data(od3), .out_last(ol3), .err_sel(err3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of traffic on dut4: drive, compare against the model, advance the model.
    task automatic step(input bit v, input logic [7:0] d, input bit l,
                        input logic [1:0] s, input logic [3:0] ordy, output bit acc);
        int tgt;
        bit erdy;
        @(negedge clk);
        v4 = v; d4 = d; l4 = l; s4 = s; or4 = ordy;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("out_valid", ov4[k], exp_q[k].size() != 0);
            if (exp_q[k].size() != 0) begin
                check("out_data", od4[k*8 +: 8], exp_q[k][0][7:0]);
                check("out_last", ol4[k], exp_q[k][0][8]);
            end
        end
        tgt  = pkt_open ? pkt_dest : int'(s);
        erdy = (exp_q[tgt].size() == 0) || ordy[tgt];
        check("in_ready", rdy4, erdy);
        check("err_sel4", err4, 1'b0);
        acc = v && erdy;
        for (int k = 0; k < 4; k++)
            if (exp_q[k].size() != 0 && ordy[k]) void'(exp_q[k].pop_front());
        if (acc) begin
            exp_q[tgt].push_back({l, d});
            if (!pkt_open && !l) begin
                pkt_open = 1;
                pkt_dest = tgt;
            end else if (pkt_open && l) begin
                pkt_open = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v4 = 1'b0; v3 = 1'b0;
        #1;
        check("rst_out_valid4", ov4, 4'h0);
        check("rst_in_ready4", rdy4, 1'b0);
        check("rst_out_data4", od4, 32'h0);
        check("rst_err3", err3, 1'b0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        pkt_open = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        int cnt;
        bit l;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", ov4, 4'h0);
        check("reset_out_last", ol4, 4'h0);
        check("reset_out_data", od4, 32'h0);
        check("reset_in_ready", rdy4, 1'b0);
        check("reset_err", err4, 1'b0);
        check("reset_in_ready3", rdy3, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single-beat packets to every channel
        for (int i = 0; i < 4; i++) begin
            step(1, 8'hA0 + 8'(i), 1, 2'(i), 4'hF, acc);
            check("single_acc", acc, 1'b1);
        end
        step(0, 8'h00, 0, 0, 4'hF, acc);

        // Multi-beat packet ignores in_sel after the first beat
        step(1, 8'h10, 0, 2, 4'hF, acc);
        step(1, 8'h11, 0, 1, 4'hF, acc);
        step(1, 8'h12, 0, 1, 4'hF, acc);
        step(1, 8'h13, 1, 1, 4'hF, acc);
        step(0, 8'h00, 0, 0, 4'hF, acc);
        check("route_ch1_idle", ov4[1], 1'b0);

        // Backpressure on channel 1
        step(1, 8'h20, 0, 1, 4'hF, acc);
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h21, 0, 1, 4'b1101, acc);
            check("bp_stall", acc, 1'b0);
            check("bp_hold", od4[15:8], 8'h20);
        end
        step(1, 8'h21, 0, 1, 4'hF, acc);
        check("bp_release", acc, 1'b1);
        step(1, 8'h22, 1, 1, 4'hF, acc);
        step(0, 8'h00, 0, 0, 4'hF, acc);

        // Out-of-range select on the 3-channel instance
        @(negedge clk);
        v4 = 1'b0;
        v3 = 1'b1; d3 = 8'h77; l3 = 1'b0; s3 = 2'd3; or3 = 3'h7;
        #1 check("oor_rdy_b0", rdy3, 1'b1);
        @(negedge clk);
        d3 = 8'h78; l3 = 1'b1; s3 = 2'd0;
        #1 check("oor_rdy_b1", rdy3, 1'b1);
        @(negedge clk);
        v3 = 1'b0;
        #1;
        check("oor_no_valid", ov3, 3'h0);
        check("oor_err", err3, 1'b1);
        @(negedge clk);
        v3 = 1'b1; d3 = 8'h55; l3 = 1'b1; s3 = 2'd0;
        @(negedge clk);
        v3 = 1'b0;
        #1;
        check("oor_next_vld", ov3, 3'b001);
        check("oor_next_data", od3[7:0], 8'h55);
        repeat (3) @(negedge clk);
        #1 check("oor_err_sticky", err3, 1'b1);

        // Reset mid-packet, then deliver to channel 3
        step(1, 8'h30, 0, 0, 4'h0, acc);
        step(1, 8'h31, 0, 0, 4'h0, acc);
        do_reset();
        step(1, 8'h40, 0, 3, 4'hF, acc);
        check("post_rst_acc", acc, 1'b1);
        step(1, 8'h41, 1, 3, 4'hF, acc);
        step(0, 8'h00, 0, 0, 4'hF, acc);

        // Back-to-back packets, downstream always ready
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            l = ($urandom_range(0, 2) == 0);
            step(1, 8'($urandom), l, 2'($urandom), 4'hF, acc);
            if (acc) cnt++;
        end
        check("no_bubbles", cnt, 40);
        step(1, 8'hEE, 1, 0, 4'hF, acc);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(bit'($urandom_range(0, 3) != 0), 8'($urandom),
                 bit'($urandom_range(0, 3) == 0), 2'($urandom),
                 4'($urandom), acc);
        end
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 4'hF, acc);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
